capp_cmd_parser: RTL and testbench



---
 rtl/capp_cmd_parser.sv | 163 ++++++++++++++++
 tb/tb_capp_cmd_parser.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capp_cmd_parser.sv
// capp_cmd_parser: frames the usb_uart byte stream into opcode/word command tokens for the CAPP FSM.
// Payload stall timeout is built only when CAPP_CMD_TIMEOUT_EN is defined.
module capp_cmd_parser #(
  parameter int unsigned NUM_BYTES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 48000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                   clk_48mhz,
  input  logic                   reset_n,
  input  logic [7:0]             uart_out_data,
  input  logic                   uart_out_valid,
  output logic                   uart_out_ready,
  output logic [3:0]             cmd_op,
  output logic [8*NUM_BYTES-1:0] cmd_word,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   err_unknown,
  output logic                   err_timeout
);

  localparam int unsigned WordW = 8 * NUM_BYTES;
  localparam int unsigned IdxW  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {StOp, StPayload, StEmit} state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [3:0]        op_q, op_d;
  logic [WordW-1:0]  word_q, word_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              err_unk_q, err_unk_d;
  logic              timeout_hit;

  logic accept, op_known, op_payload;
  assign accept     = uart_out_valid & ready_q;
  assign op_known   = (uart_out_data >= 8'h61) && (uart_out_data <= 8'h6b);
  assign op_payload = (uart_out_data == 8'h61) || (uart_out_data == 8'h63);

`ifdef CAPP_CMD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_to_q, err_to_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles only while a payload is in flight.
  always_comb begin
    cnt_d    = '0;
    err_to_d = 1'b0;
    if (state_q == StPayload && !accept) begin
      if (timeout_hit) begin
        err_to_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      err_to_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      err_to_q <= err_to_d;
    end
  end

  assign err_timeout = err_to_q;
`else
  logic unused_cfg;
  assign unused_cfg  = (CNT_W == 0) ^ (TIMEOUT_CYCLES == 0);
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    op_d      = op_q;
    word_d    = word_q;
    idx_d     = idx_q;
    err_unk_d = 1'b0;
    unique case (state_q)
      StOp: begin
        ready_d = 1'b1;
        if (accept) begin
          if (!op_known) begin
            err_unk_d = 1'b1;
          end else begin
            // 'a'..'k' have low nibbles 1..B
            op_d   = uart_out_data[3:0] - 4'd1;
            word_d = '0;
            idx_d  = '0;
            if (op_payload) begin
              state_d = StPayload;
            end else begin
              state_d = StEmit;
              ready_d = 1'b0;
              valid_d = 1'b1;
            end
          end
        end
      end
      StPayload: begin
        ready_d = 1'b1;
        if (accept) begin
          word_d[8*idx_q +: 8] = uart_out_data;
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StEmit;
            ready_d = 1'b0;
            valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          word_d  = '0;
          idx_d   = '0;
          state_d = StOp;
        end
      end
      StEmit: begin
        ready_d = 1'b0;
        valid_d = 1'b1;
        if (cmd_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = StOp;
        end
      end
      default: state_d = StOp;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      state_q   <= StOp;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      op_q      <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      err_unk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      op_q      <= op_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      err_unk_q <= err_unk_d;
    end
  end

  assign uart_out_ready = ready_q;
  assign cmd_valid      = valid_q;
  assign cmd_op         = op_q;
  assign cmd_word       = word_q;
  assign err_unknown    = err_unk_q;

endmodule

// File: tb/tb_capp_cmd_parser.sv
// Bench for capp_cmd_parser: opcode table plus hand sequences, tokens checked against a scoreboard queue.
module tb_capp_cmd_parser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  uart_out_data;
  logic        uart_out_valid;
  logic        uart_out_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_word;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        err_unknown;
  logic        err_timeout;

  always #5 clk = ~clk;

  capp_cmd_parser #(
    .NUM_BYTES      (4),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (8)
  ) dut (
    .clk_48mhz      (clk),
    .reset_n        (reset_n),
    .uart_out_data  (uart_out_data),
    .uart_out_valid (uart_out_valid),
    .uart_out_ready (uart_out_ready),
    .cmd_op         (cmd_op),
    .cmd_word       (cmd_word),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .err_unknown    (err_unknown),
    .err_timeout    (err_timeout)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] word;
  } tok_t;

  typedef struct {
    logic [7:0]  opb;
    bit          has_pl;
    logic [31:0] pl;
    bit          unk;
    logic [3:0]  op;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   tokens_seen = 0, unk_seen = 0, to_seen = 0;
  int   exp_tokens = 0, exp_unk = 0, exp_to = 0;
  tok_t exp_q[$];
  tok_t mon_tok;
  vec_t vecs[13];

  logic        prev_hold = 1'b0;
  logic [3:0]  prev_op;
  logic [31:0] prev_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [31:0] word);
    exp_q.push_back({op, word});
    exp_tokens++;
  endtask

  // Holds the byte on the bus until the parser takes it; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    uart_out_data  = b;
    uart_out_valid = 1'b1;
    @(negedge clk);
    while (!uart_out_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: byte 0x%0h got no ready in 200 cycles, required ready", b);
    end
    @(posedge clk);
    #1;
    uart_out_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  // Token scoreboard and hold-stability monitor.
  always @(negedge clk) begin
    if (reset_n) begin
      if (err_unknown) unk_seen++;
      if (err_timeout) to_seen++;
      if (prev_hold && cmd_valid) begin
        check("hold_op", cmd_op, prev_op);
        check("hold_word", cmd_word, prev_word);
      end
      if (cmd_valid && cmd_ready) begin
        tokens_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_token: got op %0d word 0x%0h, required no token", cmd_op, cmd_word);
        end else begin
          mon_tok = exp_q.pop_front();
          check("token_op", cmd_op, mon_tok.op);
          check("token_word", cmd_word, mon_tok.word);
        end
      end
    end
    prev_hold <= reset_n && cmd_valid && !cmd_ready;
    prev_op   <= cmd_op;
    prev_word <= cmd_word;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'h61, 1'b1, 32'h44332211, 1'b0, 4'd0};
    vecs[1]  = '{8'h7a, 1'b0, 32'h0,        1'b1, 4'd0};
    vecs[2]  = '{8'h78, 1'b0, 32'h0,        1'b1, 4'd0};
    vecs[3]  = '{8'h66, 1'b0, 32'h0,        1'b0, 4'd5};
    vecs[4]  = '{8'h64, 1'b0, 32'h0,        1'b0, 4'd3};
    vecs[5]  = '{8'h60, 1'b0, 32'h0,        1'b1, 4'd0};
    vecs[6]  = '{8'h6c, 1'b0, 32'h0,        1'b1, 4'd0};
    vecs[7]  = '{8'h6b, 1'b0, 32'h0,        1'b0, 4'd10};
    vecs[8]  = '{8'h63, 1'b1, 32'h80ff0102, 1'b0, 4'd2};
    vecs[9]  = '{8'h65, 1'b0, 32'h0,        1'b0, 4'd4};
    vecs[10] = '{8'h67, 1'b0, 32'h0,        1'b0, 4'd6};
    vecs[11] = '{8'h68, 1'b0, 32'h0,        1'b0, 4'd7};
    vecs[12] = '{8'h69, 1'b0, 32'h0,        1'b0, 4'd8};

    reset_n        = 1'b0;
    uart_out_data  = 8'h00;
    uart_out_valid = 1'b0;
    cmd_ready      = 1'b1;

    // Reset values, then ready rises on the first cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", uart_out_ready, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_op", cmd_op, 0);
    check("rst_word", cmd_word, 0);
    check("rst_err_unknown", err_unknown, 0);
    check("rst_err_timeout", err_timeout, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_before_edge", uart_out_ready, 0);
    @(negedge clk);
    check("ready_after_release", uart_out_ready, 1);
    @(posedge clk);
    #1;

    // 'b' with cmd_ready high.
    push_exp(4'd1, 32'h0);
    send_byte(8'h62);
    @(negedge clk);
    check("b_valid", cmd_valid, 1);
    check("b_op", cmd_op, 1);
    check("b_word", cmd_word, 0);
    @(negedge clk);
    check("b_ready_after_hs", uart_out_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].unk) begin
        exp_unk++;
        send_byte(vecs[i].opb);
        @(negedge clk);
        check("unk_pulse", err_unknown, 1);
        check("unk_no_valid", cmd_valid, 0);
        check("unk_ready", uart_out_ready, 1);
        @(negedge clk);
        check("unk_pulse_end", err_unknown, 0);
      end else begin
        push_exp(vecs[i].op, vecs[i].has_pl ? vecs[i].pl : 32'h0);
        send_byte(vecs[i].opb);
        if (vecs[i].has_pl) send_word(vecs[i].pl);
        @(negedge clk);
        check("vec_valid", cmd_valid, 1);
        check("vec_ready_low", uart_out_ready, 0);
      end
      @(posedge clk);
      #1;
    end

    // 'c' held by downstream back-pressure with a byte waiting upstream.
    cmd_ready = 1'b0;
    push_exp(4'd2, 32'hddccbbaa);
    send_byte(8'h63);
    send_word(32'hddccbbaa);
    push_exp(4'd4, 32'h0);
    uart_out_data  = 8'h65;
    uart_out_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_valid", cmd_valid, 1);
      check("bp_ready", uart_out_ready, 0);
      check("bp_op", cmd_op, 2);
      check("bp_word", cmd_word, 32'hddccbbaa);
    end
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    send_byte(8'h65);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;

`ifdef CAPP_CMD_TIMEOUT_EN
    begin
      int n;
      exp_to++;
      send_byte(8'h61);
      send_byte(8'h01);
      n = 0;
      do begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end while (!err_timeout && n < 40);
      check("timeout_cycle", n, 16);
      check("timeout_no_valid", cmd_valid, 0);
      check("timeout_ready", uart_out_ready, 1);
      @(negedge clk);
      check("timeout_pulse_end", err_timeout, 0);
      @(posedge clk);
      #1;
      push_exp(4'd0, 32'h04030201);
      send_byte(8'h61);
      send_word(32'h04030201);
    end
`else
    send_byte(8'h61);
    send_byte(8'h01);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("stall_no_valid", cmd_valid, 0);
      check("stall_ready", uart_out_ready, 1);
    end
    @(posedge clk);
    #1;
    push_exp(4'd0, 32'h04030201);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
`endif
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;

    // Reset while 'k' waits for cmd_ready drops it silently.
    cmd_ready = 1'b0;
    send_byte(8'h6b);
    @(negedge clk);
    check("k_pending", cmd_valid, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_err_unknown", err_unknown, 0);
    check("mid_rst_err_timeout", err_timeout, 0);
    @(negedge clk);
    check("mid_rst_ready", uart_out_ready, 1);
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    push_exp(4'd9, 32'h0);
    send_byte(8'h6a);
    repeat (5) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    check("token_count", tokens_seen, exp_tokens);
    check("unknown_pulses", unk_seen, exp_unk);
    check("timeout_pulses", to_seen, exp_to);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
